// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit type and arbiter state encoding.
package noc_pkg;

  localparam int unsigned FLIT_W   = 14;
  localparam int unsigned DST_MSB  = 12;
  localparam int unsigned DST_LSB  = 11;
  localparam int unsigned TYPE_MSB = 10;
  localparam int unsigned TYPE_LSB = 9;
  localparam int unsigned PAY_MSB  = 8;
  localparam int unsigned PAY_LSB  = 1;
  localparam int unsigned EOP_BIT  = 0;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/noc_rr_picker.sv
// Round-robin first-one search: the first set request at or above ptr, wrapping modulo N.
module noc_rr_picker #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             found
);

  int unsigned idx;

  // Scan requests starting from ptr; the first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Output-port arbiter for the 2x2 mesh router: round-robin, packet-granular
// (wormhole) grant, with a 1-entry registered output buffer.
// Optional stall watchdog enabled by defining NOC_ARB_WATCHDOG_EN.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter  int unsigned N_IN      = 4,
  parameter  int unsigned FLIT_W    = noc_pkg::FLIT_W,
  parameter  int unsigned CNT_W     = 16,
  parameter  int unsigned MAX_STALL = 15,
  localparam int unsigned IDX_W     = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_IN-1:0]             in_valid,
  input  logic [N_IN-1:0][FLIT_W-1:0] in_flit,
  output logic [N_IN-1:0]             in_ready,
  output logic                        out_valid,
  output logic [FLIT_W-1:0]           out_flit,
  input  logic                        out_ready,
  output logic [IDX_W-1:0]            grant_id,
  output logic                        busy,
  output logic [CNT_W-1:0]            pkt_count,
  output logic                        err_timeout
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]  out_flit_q, out_flit_d;
  logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               can_load;
  logic               accept;
  logic [IDX_W-1:0]   next_ptr;

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;
`else
  logic unused_max_stall;
  assign unused_max_stall = (MAX_STALL != 0);
`endif

  noc_rr_picker #(.N(N_IN)) u_picker (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_idx),
    .found (pick_found)
  );

  assign can_load = !out_valid_q || out_ready;
  assign next_ptr = (grant_q == IDX_W'(N_IN - 1)) ? '0 : grant_q + IDX_W'(1);

  // Next-state, output-buffer and counter logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q && !out_ready;
    out_flit_d  = out_flit_q;
    pkt_count_d = pkt_count_q;
    in_ready    = '0;
    accept      = 1'b0;
`ifdef NOC_ARB_WATCHDOG_EN
    stall_d     = stall_q;
    err_d       = 1'b0;
`endif
    if (out_valid_q && out_ready && out_flit_q[EOP_BIT])
      pkt_count_d = pkt_count_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
`ifdef NOC_ARB_WATCHDOG_EN
        stall_d = '0;
`endif
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        in_ready[grant_q] = can_load;
        accept = in_valid[grant_q] && can_load;
        if (accept) begin
          out_flit_d  = in_flit[grant_q];
          out_valid_d = 1'b1;
          if (in_flit[grant_q][EOP_BIT]) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
`ifdef NOC_ARB_WATCHDOG_EN
        if (accept) begin
          stall_d = '0;
        end else if (!in_valid[grant_q]) begin
          if (stall_q == STALL_W'(MAX_STALL - 1)) begin
            stall_d  = '0;
            err_d    = 1'b1;
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      pkt_count_q <= '0;
`ifdef NOC_ARB_WATCHDOG_EN
      stall_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      pkt_count_q <= pkt_count_d;
`ifdef NOC_ARB_WATCHDOG_EN
      stall_q     <= stall_d;
      err_q       <= err_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == LOCK);
  assign pkt_count = pkt_count_q;
`ifdef NOC_ARB_WATCHDOG_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: per-input source queues,
// an expected-flit scoreboard and a packet table for round-robin order.
module tb_noc_output_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       in_valid;
  logic [3:0][13:0] in_flit;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [13:0]      out_flit;
  logic             out_ready;
  logic [1:0]       grant_id;
  logic             busy;
  logic [15:0]      pkt_count;
  logic             err_timeout;

  typedef struct {logic [13:0] f; int gap;} src_ent_t;
  typedef struct {logic [13:0] f; logic [1:0] g; bit chk_g;} exp_ent_t;
  typedef struct {int src; int len; int exp_grant;} pkt_vec_t;

  src_ent_t srcq[4][$];
  exp_ent_t expq[$];
  int  nvec = 0;
  int  nmis = 0;
  int  n_err = 0;
  bit  drv_en = 1'b0;
  int  k;
  pkt_vec_t vt[5];

  noc_output_arbiter #(.N_IN(4), .FLIT_W(14), .CNT_W(16), .MAX_STALL(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_flit     (in_flit),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_flit    (out_flit),
    .out_ready   (out_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_count   (pkt_count),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mkflit(int src, int pkt, int idx, bit eop);
    logic [1:0] s;
    logic [3:0] p;
    logic [1:0] ix;
    s  = src[1:0];
    p  = pkt[3:0];
    ix = idx[1:0];
    return {1'b0, s, 2'b01, s, p, ix, eop};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(logic [13:0] f, int g);
    exp_ent_t e;
    e.f = f;
    e.g = g[1:0];
    e.chk_g = 1'b1;
    expq.push_back(e);
  endtask

  task automatic send_pkt(int src, int pkt, int len, int g, int gap_at, int gap_len, bit exp_push);
    src_ent_t s;
    for (int i = 0; i < len; i++) begin
      s.f   = mkflit(src, pkt, i, i == len - 1);
      s.gap = (i == gap_at) ? gap_len : 0;
      srcq[src].push_back(s);
      if (exp_push) push_exp(s.f, g);
    end
  endtask

  function automatic bit src_busy();
    for (int i = 0; i < 4; i++)
      if (srcq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic flush_all();
    for (int i = 0; i < 4; i++) srcq[i].delete();
    expq.delete();
  endtask

  task automatic wait_drain(int budget);
    int c;
    c = 0;
    while ((expq.size() != 0 || src_busy()) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("drain_in_budget", 32'(c < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_out_valid(string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_valid && c < 30);
    chk(name, 32'(out_valid), 1);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    flush_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Source driver: handshake sampled at negedge, inputs updated just after posedge.
  initial begin : drv
    bit acc[4];
    src_ent_t e;
    in_valid = '0;
    in_flit  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) acc[i] = in_valid[i] && in_ready[i];
      @(posedge clk);
      #1;
      if (drv_en) begin
        for (int i = 0; i < 4; i++) begin
          if (acc[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
          if (srcq[i].size() != 0) begin
            e = srcq[i][0];
            if (e.gap > 0) begin
              e.gap--;
              srcq[i][0] = e;
              in_valid[i] = 1'b0;
            end else begin
              in_valid[i] = 1'b1;
              in_flit[i]  = e.f;
            end
          end else begin
            in_valid[i] = 1'b0;
          end
        end
      end
    end
  end

  // Output monitor: every delivered flit is checked against the scoreboard.
  initial begin : mon
    exp_ent_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL unexpected_flit: got %0h, expected no flit", out_flit);
        end else begin
          e = expq.pop_front();
          chk("out_flit", 32'(out_flit), 32'(e.f));
          if (e.chk_g) chk("grant_at_out", 32'(grant_id), 32'(e.g));
        end
      end
      if (rst_n && err_timeout) n_err++;
    end
  end

  initial begin : watchdog_tb
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    vt[0] = '{src: 0, len: 2, exp_grant: 0};
    vt[1] = '{src: 1, len: 2, exp_grant: 1};
    vt[2] = '{src: 2, len: 2, exp_grant: 2};
    vt[3] = '{src: 3, len: 2, exp_grant: 3};
    vt[4] = '{src: 0, len: 2, exp_grant: 0};

    // 1: reset held with inputs toggling
    rst_n = 1'b0;
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid  = 4'($urandom);
      for (int i = 0; i < 4; i++) in_flit[i] = 14'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_flit", 32'(out_flit), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_pkt_count", 32'(pkt_count), 0);
      chk("rst_err", 32'(err_timeout), 0);
    end
    @(posedge clk);
    #1;
    in_valid  = '0;
    out_ready = 1'b1;
    drv_en    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2: single 3-flit packet from input 0
    send_pkt(0, 0, 3, 0, -1, 0, 1'b1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_valid[0] && k < 20);
    chk("t2_idle_no_accept", 32'(in_ready[0]), 0);
    chk("t2_idle_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t2_grant", 32'(grant_id), 0);
    chk("t2_lock_ready", 32'(in_ready[0]), 1);
    @(negedge clk);
    chk("t2_latency_valid", 32'(out_valid), 1);
    chk("t2_latency_flit", 32'(out_flit), 32'(mkflit(0, 0, 0, 0)));
    wait_drain(50);
    chk("t2_pkt_count", 32'(pkt_count), 1);
    chk("t2_idle_after_eop", 32'(busy), 0);

    // 3: all inputs contend, expected order from the table
    reset_dut();
    for (int p = 0; p < 5; p++)
      send_pkt(vt[p].src, p, vt[p].len, vt[p].exp_grant, -1, 0, 1'b1);
    wait_drain(200);
    chk("t3_pkt_count", 32'(pkt_count), 5);

    // 4: downstream stall for 5 cycles mid-packet
    send_pkt(2, 6, 4, 2, -1, 0, 1'b1);
    wait_out_valid("t4_first_out");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_hold_flit", 32'(out_flit), 32'(mkflit(2, 6, 1, 0)));
      chk("t4_hold_valid", 32'(out_valid), 1);
      chk("t4_owner_ready", 32'(in_ready[2]), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain(50);
    chk("t4_pkt_count", 32'(pkt_count), 6);

    // 5: owner 1 stalls after head while input 2 waits
    n_err = 0;
    send_pkt(1, 7, 3, 1, 1, 20, 1'b0);
    send_pkt(2, 8, 1, 2, -1, 0, 1'b0);
    push_exp(mkflit(1, 7, 0, 0), 1);
`ifdef NOC_ARB_WATCHDOG_EN
    push_exp(mkflit(2, 8, 0, 1), 2);
    push_exp(mkflit(1, 7, 1, 0), 1);
    push_exp(mkflit(1, 7, 2, 1), 1);
`else
    push_exp(mkflit(1, 7, 1, 0), 1);
    push_exp(mkflit(1, 7, 2, 1), 1);
    push_exp(mkflit(2, 8, 0, 1), 2);
`endif
    wait_out_valid("t5_head_out");
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("t5_nonowner_ready", 32'(in_ready[2]), 0);
      chk("t5_grant_held", 32'(grant_id), 1);
      chk("t5_busy", 32'(busy), 1);
    end
    wait_drain(100);
`ifdef NOC_ARB_WATCHDOG_EN
    chk("t5_err_pulses", 32'(n_err), 1);
`else
    chk("t5_err_pulses", 32'(n_err), 0);
`endif
    chk("t5_pkt_count", 32'(pkt_count), 8);

    // 6: reset mid-packet, then a clean packet
    send_pkt(0, 9, 5, 0, -1, 0, 1'b1);
    wait_out_valid("t6_first_out");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    flush_all();
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 0);
    chk("t6_rst_pkt_count", 32'(pkt_count), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    send_pkt(3, 10, 2, 3, -1, 0, 1'b1);
    wait_drain(50);
    chk("t6_pkt_count", 32'(pkt_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
